// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one external shift-add multiplier among NREQ requesters.
// One operation in flight: grant in IDLE, load pulse, fixed LAT-cycle wait, capture product.
module mult_arbiter #(
   parameter int M    = 8,
   parameter int N    = 16,
   parameter int NREQ = 4,
   parameter int LAT  = 10
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NREQ-1:0]            req,
   input  logic [NREQ*M-1:0]          req_a,
   input  logic [NREQ*M-1:0]          req_b,
   output logic [NREQ-1:0]            gnt,
   output logic                       rsp_valid,
   output logic [$clog2(NREQ)-1:0]    rsp_id,
   output logic [N-1:0]               rsp_p,
   output logic                       mul_ea,
   output logic                       mul_eb,
   output logic [M-1:0]               mul_a,
   output logic [M-1:0]               mul_b,
   input  logic [N-1:0]               mul_p
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(LAT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_WAIT = 2'd2,
      S_CAP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   rr_q, rr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [M-1:0]    op_a_q, op_a_d;
   logic [M-1:0]    op_b_q, op_b_d;
   logic [IW-1:0]   op_id_q, op_id_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [IW-1:0]   rsp_id_q, rsp_id_d;
   logic [N-1:0]    rsp_p_q, rsp_p_d;

   logic [M-1:0]    a_arr [NREQ];
   logic [M-1:0]    b_arr [NREQ];
   logic            sel_found;
   logic [IW-1:0]   sel_idx;
   logic [IW-1:0]   cand;
   logic [NREQ-1:0] gnt_c;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign a_arr[gi] = req_a[gi*M +: M];
         assign b_arr[gi] = req_b[gi*M +: M];
      end
   endgenerate

   // Search starts at rr_q; the IW-bit sum wraps NREQ-1 back to 0.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = rr_q + IW'(k);
         if (!sel_found && req[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      cnt_d       = cnt_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_id_d     = op_id_q;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_p_d     = rsp_p_q;
      gnt_c       = '0;
      case (state_q)
         S_IDLE: begin
            if (sel_found) begin
               gnt_c[sel_idx] = 1'b1;
               op_a_d         = a_arr[sel_idx];
               op_b_d         = b_arr[sel_idx];
               op_id_d        = sel_idx;
               rr_d           = sel_idx + IW'(1);
               state_d        = S_LOAD;
            end
         end
         S_LOAD: begin
            cnt_d   = CW'(LAT - 1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_CAP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_CAP: begin
            rsp_valid_d = 1'b1;
            rsp_p_d     = mul_p;
            rsp_id_d    = op_id_q;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rr_q        <= '0;
         cnt_q       <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_id_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_p_q     <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         cnt_q       <= cnt_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_id_q     <= op_id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_p_q     <= rsp_p_d;
      end
   end

   // State is already IDLE while reset is held, so the grant must also be gated by rst_n.
   assign gnt       = rst_n ? gnt_c : '0;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_p     = rsp_p_q;
   assign mul_ea    = (state_q == S_LOAD);
   assign mul_eb    = (state_q == S_LOAD);
   assign mul_a     = op_a_q;
   assign mul_b     = op_b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed and random checks of mult_arbiter against a behavioural LAT-cycle multiplier.
module tb_mult_arbiter;
   localparam int M = 8, N = 16, NREQ = 4, LAT = 10;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [3:0]     req = '0;
   logic [31:0]    req_a = '0, req_b = '0;
   logic [3:0]     gnt;
   logic           rsp_valid;
   logic [1:0]     rsp_id;
   logic [15:0]    rsp_p;
   logic           mul_ea, mul_eb;
   logic [7:0]     mul_a, mul_b;
   logic [15:0]    mul_p;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mult_arbiter #(.M(M), .N(N), .NREQ(NREQ), .LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p),
      .mul_ea(mul_ea), .mul_eb(mul_eb), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
   );

   // Multiplier model: garbage until LAT edges after the load edge, then the true product.
   logic [7:0] m_a, m_b;
   int         mcnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcnt <= 0; mul_p <= '0; m_a <= '0; m_b <= '0;
      end else if (mul_ea && mul_eb) begin
         m_a <= mul_a; m_b <= mul_b; mcnt <= LAT; mul_p <= 16'hDEAD;
      end else if (mcnt != 0) begin
         mcnt <= mcnt - 1;
         if (mcnt == 1) mul_p <= {8'h00, m_a} * {8'h00, m_b};
      end
   end

   task automatic wait_gnt(output logic [3:0] g);
      g = '0;
      for (int i = 0; i < 40; i++) begin
         if (gnt != 4'b0000) begin
            g = gnt;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_rsp(input int start, output int lat, output bit saw_gnt);
      lat = 99;
      saw_gnt = 1'b0;
      for (int c = start + 1; c <= 40; c++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = c;
            break;
         end
         if (gnt != 4'b0000) saw_gnt = 1'b1;
      end
   endtask

   task automatic set_op(input int idx, input logic [7:0] a, input logic [7:0] b);
      req_a[idx*8 +: 8] = a;
      req_b[idx*8 +: 8] = b;
   endtask

   task automatic reset_dut();
      @(posedge clk); #1;
      rst_n = 1'b0; req = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      req = 4'b1111;
      set_op(0, 8'd1, 8'd2);
      #2;
      vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
      vectors++; if (rsp_p !== 16'd0 || rsp_id !== 2'd0) begin miscompares++; $display("FAIL reset_rsp got p=%0d id=%0d want 0/0", rsp_p, rsp_id); end
      vectors++; if ({mul_ea, mul_eb} !== 2'b00 || mul_a !== 8'd0 || mul_b !== 8'd0) begin miscompares++; $display("FAIL reset_mul got ea=%b eb=%b a=%0d b=%0d want all 0", mul_ea, mul_eb, mul_a, mul_b); end
      req = '0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      vectors++; if (gnt !== 4'b0000 || mul_ea !== 1'b0) begin miscompares++; $display("FAIL idle_no_req got gnt=%b ea=%b want 0000/0", gnt, mul_ea); end
      $display("txn reset: outputs checked");
   endtask

   task automatic test_single();
      logic [3:0] g; int lat; bit sg;
      @(posedge clk); #1;
      req = 4'b0001; set_op(0, 8'd12, 8'd13);
      @(negedge clk);
      wait_gnt(g);
      vectors++; if (g !== 4'b0001) begin miscompares++; $display("FAIL single_gnt got=%b want=0001", g); end
      @(posedge clk); #1 req = '0;
      @(negedge clk);
      vectors++; if ({mul_ea, mul_eb} !== 2'b11 || mul_a !== 8'd12 || mul_b !== 8'd13) begin miscompares++; $display("FAIL single_load got ea=%b eb=%b a=%0d b=%0d want 1 1 12 13", mul_ea, mul_eb, mul_a, mul_b); end
      @(negedge clk);
      vectors++; if ({mul_ea, mul_eb} !== 2'b00 || mul_a !== 8'd12 || mul_b !== 8'd13) begin miscompares++; $display("FAIL single_hold got ea=%b eb=%b a=%0d b=%0d want 0 0 12 13", mul_ea, mul_eb, mul_a, mul_b); end
      wait_rsp(2, lat, sg);
      vectors++; if (lat !== 13) begin miscompares++; $display("FAIL single_latency got=%0d want=13", lat); end
      vectors++; if (rsp_p !== 16'd156 || rsp_id !== 2'd0) begin miscompares++; $display("FAIL single_result got p=%0d id=%0d want 156/0", rsp_p, rsp_id); end
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b0 || rsp_p !== 16'd156 || rsp_id !== 2'd0) begin miscompares++; $display("FAIL single_strobe got v=%b p=%0d id=%0d want 0/156/0", rsp_valid, rsp_p, rsp_id); end
      $display("txn single: gnt=%b lat=%0d id=%0d p=%0d", g, lat, rsp_id, rsp_p);
   endtask

   task automatic test_all_requesters();
      logic [3:0] g; int lat; bit sg;
      logic [15:0] exp_p [4] = '{16'd12, 16'd30, 16'd65025, 16'd0};
      reset_dut();
      @(posedge clk); #1;
      set_op(0, 8'd3, 8'd4); set_op(1, 8'd5, 8'd6); set_op(2, 8'd255, 8'd255); set_op(3, 8'd0, 8'd200);
      req = 4'b1111;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         wait_gnt(g);
         vectors++; if (g !== (4'b0001 << k)) begin miscompares++; $display("FAIL all_gnt[%0d] got=%b want=%b", k, g, 4'b0001 << k); end
         @(posedge clk); #1 req[k] = 1'b0;
         wait_rsp(0, lat, sg);
         vectors++; if (lat !== 13) begin miscompares++; $display("FAIL all_latency[%0d] got=%0d want=13", k, lat); end
         vectors++; if (rsp_p !== exp_p[k] || rsp_id !== 2'(k)) begin miscompares++; $display("FAIL all_result[%0d] got p=%0d id=%0d want %0d/%0d", k, rsp_p, rsp_id, exp_p[k], k); end
         $display("txn all: gnt=%b lat=%0d id=%0d p=%0d", g, lat, rsp_id, rsp_p);
      end
   endtask

   task automatic test_fairness();
      logic [3:0] g; int lat; bit sg; int idx;
      reset_dut();
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) set_op(i, 8'(i + 2), 8'd3);
      req = 4'b1111;
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         idx = k % 4;
         wait_gnt(g);
         vectors++; if (g !== (4'b0001 << idx)) begin miscompares++; $display("FAIL fair_gnt[%0d] got=%b want=%b", k, g, 4'b0001 << idx); end
         wait_rsp(0, lat, sg);
         vectors++; if (lat !== 13 || rsp_id !== 2'(idx) || rsp_p !== 16'((idx + 2) * 3)) begin miscompares++; $display("FAIL fair_result[%0d] got lat=%0d id=%0d p=%0d want 13/%0d/%0d", k, lat, rsp_id, rsp_p, idx, (idx + 2) * 3); end
         $display("txn fair: gnt=%b id=%0d p=%0d", g, rsp_id, rsp_p);
      end
      @(posedge clk); #1 req = '0;
   endtask

   task automatic test_wrap();
      logic [3:0] g; int lat; bit sg;
      reset_dut();
      @(posedge clk); #1;
      set_op(3, 8'd9, 8'd9); set_op(0, 8'd4, 8'd5);
      req = 4'b1000;
      @(negedge clk);
      wait_gnt(g);
      vectors++; if (g !== 4'b1000) begin miscompares++; $display("FAIL wrap_first got=%b want=1000", g); end
      @(posedge clk); #1 req = 4'b1001;
      wait_rsp(0, lat, sg);
      vectors++; if (sg !== 1'b0) begin miscompares++; $display("FAIL wrap_busy_gnt got=%b want=0", sg); end
      vectors++; if (lat !== 13 || rsp_p !== 16'd81 || rsp_id !== 2'd3) begin miscompares++; $display("FAIL wrap_res3 got lat=%0d p=%0d id=%0d want 13/81/3", lat, rsp_p, rsp_id); end
      wait_gnt(g);
      vectors++; if (g !== 4'b0001) begin miscompares++; $display("FAIL wrap_to0 got=%b want=0001", g); end
      wait_rsp(0, lat, sg);
      vectors++; if (lat !== 13 || rsp_p !== 16'd20 || rsp_id !== 2'd0) begin miscompares++; $display("FAIL wrap_res0 got lat=%0d p=%0d id=%0d want 13/20/0", lat, rsp_p, rsp_id); end
      wait_gnt(g);
      vectors++; if (g !== 4'b1000) begin miscompares++; $display("FAIL wrap_to3 got=%b want=1000", g); end
      @(posedge clk); #1 req = '0;
      wait_rsp(0, lat, sg);
      vectors++; if (lat !== 13 || rsp_p !== 16'd81 || rsp_id !== 2'd3) begin miscompares++; $display("FAIL wrap_res3b got lat=%0d p=%0d id=%0d want 13/81/3", lat, rsp_p, rsp_id); end
      $display("txn wrap: grants 3,0,3 last p=%0d", rsp_p);
   endtask

   task automatic test_reset_mid_wait();
      logic [3:0] g; int lat; bit sg; bit seen;
      reset_dut();
      @(posedge clk); #1;
      set_op(0, 8'd7, 8'd9); req = 4'b0001;
      @(negedge clk);
      wait_gnt(g);
      @(posedge clk); #1 req = '0;
      wait_rsp(0, lat, sg);
      vectors++; if (rsp_p !== 16'd63) begin miscompares++; $display("FAIL rmw_pre got p=%0d want 63", rsp_p); end
      @(posedge clk); #1;
      set_op(1, 8'd11, 8'd12); req = 4'b0010;
      @(negedge clk);
      wait_gnt(g);
      vectors++; if (g !== 4'b0010) begin miscompares++; $display("FAIL rmw_gnt got=%b want=0010", g); end
      repeat (6) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      vectors++; if (gnt !== 4'b0000 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_p !== 16'd0) begin miscompares++; $display("FAIL rmw_outs got gnt=%b v=%b id=%0d p=%0d want 0", gnt, rsp_valid, rsp_id, rsp_p); end
      vectors++; if ({mul_ea, mul_eb} !== 2'b00 || mul_a !== 8'd0 || mul_b !== 8'd0) begin miscompares++; $display("FAIL rmw_mul got ea=%b eb=%b a=%0d b=%0d want 0", mul_ea, mul_eb, mul_a, mul_b); end
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid || gnt != 4'b0000) seen = 1'b1;
      end
      vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rmw_quiet got activity=%b want 0", seen); end
      @(posedge clk); #1;
      rst_n = 1'b1; req = 4'b0110; set_op(2, 8'd2, 8'd2);
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rmw_no_rsp got=%b want 0", rsp_valid); end
      wait_gnt(g);
      vectors++; if (g !== 4'b0010) begin miscompares++; $display("FAIL rmw_after got=%b want=0010", g); end
      @(posedge clk); #1 req = '0;
      wait_rsp(0, lat, sg);
      vectors++; if (lat !== 13 || rsp_p !== 16'd132 || rsp_id !== 2'd1) begin miscompares++; $display("FAIL rmw_result got lat=%0d p=%0d id=%0d want 13/132/1", lat, rsp_p, rsp_id); end
      $display("txn reset_mid_wait: post-reset gnt=%b p=%0d", g, rsp_p);
   endtask

   task automatic test_random();
      logic [3:0] g, mask, eg; int lat; bit sg; int rrm, idx, c;
      logic [7:0] ea, eb; logic [15:0] ep;
      reset_dut();
      rrm = 0;
      for (int op = 0; op < 200; op++) begin
         @(posedge clk); #1;
         mask  = 4'($urandom_range(1, 15));
         req_a = $urandom;
         req_b = $urandom;
         req   = mask;
         idx = 0;
         for (int k = 3; k >= 0; k--) begin
            c = (rrm + k) % 4;
            if (mask[c]) idx = c;
         end
         ea = req_a[idx*8 +: 8];
         eb = req_b[idx*8 +: 8];
         ep = {8'h00, ea} * {8'h00, eb};
         eg = 4'b0001 << idx;
         rrm = (idx + 1) % 4;
         @(negedge clk);
         wait_gnt(g);
         vectors++; if (g !== eg) begin miscompares++; $display("FAIL rand_gnt[%0d] got=%b want=%b", op, g, eg); end
         @(posedge clk); #1 req = '0;
         wait_rsp(0, lat, sg);
         vectors++; if (lat !== 13 || rsp_id !== 2'(idx)) begin miscompares++; $display("FAIL rand_id[%0d] got lat=%0d id=%0d want 13/%0d", op, lat, rsp_id, idx); end
         vectors++; if (rsp_p !== ep) begin miscompares++; $display("FAIL rand_p[%0d] got=%0d want=%0d", op, rsp_p, ep); end
         $display("txn rand %0d: mask=%b gnt=%b id=%0d p=%0d", op, mask, g, rsp_id, rsp_p);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_requesters();
      test_fairness();
      test_wrap();
      test_reset_mid_wait();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter M, default 8, meaning operand width.
REQ-002 SHALL have parameter N, default 16, meaning product width (2*M).
REQ-003 SHALL have parameter NREQ, default 4, meaning requester count (power of 2, >=2).
REQ-004 SHALL have parameter LAT, default 10 (M+2), meaning multiplier cycles from load edge to valid P.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port req, input, NREQ, meaning per-requester multiply request (level).
REQ-008 SHALL have port req_a, input, NREQ*M, meaning operand A, requester i at bits [i*M +: M].
REQ-009 SHALL have port req_b, input, NREQ*M, meaning operand B, same packing.
REQ-010 SHALL have port gnt, output, NREQ, meaning one-hot one-cycle acceptance pulse.
REQ-011 SHALL have port rsp_valid, output, 1, meaning one-cycle result strobe.
REQ-012 SHALL have port rsp_id, output, log2(NREQ), meaning index of requester owning the result.
REQ-013 SHALL have port rsp_p, output, N, meaning product result.
REQ-014 SHALL have ports mul_ea and mul_eb, output, 1 each, meaning load enables to the shared shift-add multiplier.
REQ-015 SHALL have ports mul_a and mul_b, output, M each, meaning operands to the multiplier.
REQ-016 SHALL have port mul_p, input, N, meaning multiplier product P.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, WAIT, CAP.
REQ-018 IDLE: if any req bit set, gnt SHALL assert combinationally for exactly one requester selected round-robin from pointer rr; the selected requester's operands and index SHALL be registered at that edge; next state LOAD. Otherwise stay IDLE, gnt=0.
REQ-019 Round-robin: search SHALL start at index rr, wrap NREQ-1 -> 0; after a grant to i, rr SHALL become (i+1) mod NREQ; rr unchanged when no grant.
REQ-020 LOAD: mul_ea=mul_eb=1 for exactly this one cycle, mul_a/mul_b = captured operands; the edge ending LOAD is the load edge; next state WAIT with counter = LAT-1.
REQ-021 WAIT SHALL last exactly LAT cycles (counter decrements to 0), then CAP.
REQ-022 CAP: at the edge ending CAP, rsp_p <= mul_p, rsp_id <= captured index, rsp_valid <= 1; next state IDLE.
REQ-023 rsp_valid SHALL be high for exactly one cycle; rsp_p and rsp_id SHALL hold until the next CAP edge.
REQ-024 Latency SHALL be fixed: gnt in cycle t gives rsp_valid in cycle t+LAT+3 (t+13 at defaults); a new gnt MAY coincide with rsp_valid.
REQ-025 mul_ea, mul_eb SHALL be 0 and mul_a, mul_b SHALL hold last captured values in all states except LOAD.
REQ-026 Requests arriving in LOAD/WAIT/CAP SHALL not be granted until IDLE; requesters hold req and operands until gnt; a req dropped before gnt is simply not served.
REQ-027 At most one operation SHALL be in flight; no queuing.
REQ-028 Product SHALL be unsigned full width; 0*x=0 and 255*255=65025 returned exactly.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, rr=0, counter=0, gnt=0, rsp_valid=0, rsp_id=0, rsp_p=0, mul_ea=mul_eb=0, mul_a=mul_b=0.
REQ-030 Reset during LOAD/WAIT/CAP SHALL abandon the operation with no rsp_valid; after release, the first grant SHALL follow round-robin from rr=0.

Verification
REQ-031 Single request: req=0001, a0=12, b0=13 -> gnt=0001 same cycle, mul_ea/eb pulse next cycle, rsp_valid 13 cycles after gnt, rsp_id=0, rsp_p=156.
REQ-032 All requesters, operands (3,4),(5,6),(255,255),(0,200) held -> grants in order 0,1,2,3, results 12,30,65025,0 with matching rsp_id, each 13 cycles after its gnt.
REQ-033 Fairness: req=1111 continuous for 8 operations -> grant sequence 0,1,2,3,0,1,2,3; no requester served twice while another waits.
REQ-034 Wrap: after grant to 3, req=1001 -> next grant to 0; after grant to 0, req=1001 -> next grant to 3.
REQ-035 Reset mid-WAIT: assert rst_n low 5 cycles after LOAD -> all outputs 0 immediately, no rsp_valid; after release req=0110 -> grant to 1.
REQ-036 Random: 200 operations, random req masks and 8-bit operands, bench model of round-robin and a*b -> every rsp_p and rsp_id match, 0 mismatches reported in summary.
